// File: rtl/power_logic_pkg.sv
// Shared types and default parameters for the power-domain switch sequencer.
package power_logic_pkg;

  localparam int DEF_STAGES      = 4;
  localparam int DEF_STEP_CYCLES = 8;
  localparam int DEF_ACK_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PWRUP,
    ST_WAITACK,
    ST_ON,
    ST_ISOLATE,
    ST_PWRDN
  } pwr_state_e;

endpackage

// File: rtl/power_logic_sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module power_logic_sync2 (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/power_logic_seq_ctrl.sv
// Power-domain sequencer: staged switch enables, ack wait with timeout, isolation, reverse power-down.
// Define POWER_LOGIC_SEQ_ACK_SYNC_EN to pass pwr_ack through a 2-flop synchronizer.
module power_logic_seq_ctrl
  import power_logic_pkg::*;
#(
  parameter int STAGES      = DEF_STAGES,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pwr_req,
  input  logic              pwr_ack,
  input  logic              err_clr,
  output logic [STAGES-1:0] stage_en_n,
  output logic              iso_en,
  output logic              pwr_on,
  output logic              busy,
  output logic              timeout_err
);

  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);

  pwr_state_e        state_q, state_d;
  logic [STAGES-1:0] stage_q, stage_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              iso_q, on_q, busy_q;
  logic              ack;

`ifdef POWER_LOGIC_SEQ_ACK_SYNC_EN
  power_logic_sync2 u_ack_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (pwr_ack),
    .q      (ack)
  );
`else
  assign ack = pwr_ack;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    err_d   = err_clr ? 1'b0 : err_q;

    // Stages switch on from bit 0 upward (shift a 0 in) and off from the top down (shift a 1 in).
    case (state_q)
      ST_OFF: begin
        if (pwr_req && !err_q) begin
          state_d = ST_PWRUP;
          stage_d = {stage_q[STAGES-2:0], 1'b0};
          step_d  = '0;
        end
      end
      ST_PWRUP: begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          if (!stage_q[STAGES-1]) begin
            state_d = ST_WAITACK;
            tmo_d   = '0;
          end else begin
            stage_d = {stage_q[STAGES-2:0], 1'b0};
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_WAITACK: begin
        if (ack) begin
          state_d = ST_ON;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_PWRDN;
          err_d   = 1'b1;
          stage_d = {1'b1, stage_q[STAGES-1:1]};
          step_d  = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_ON: begin
        if (!pwr_req) begin
          state_d = ST_ISOLATE;
          step_d  = '0;
        end
      end
      ST_ISOLATE: begin
        if (step_q == STEP_LAST) begin
          state_d = ST_PWRDN;
          stage_d = {1'b1, stage_q[STAGES-1:1]};
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_PWRDN: begin
        if (stage_q[0]) begin
          state_d = ST_OFF;
        end else if (step_q == STEP_LAST) begin
          stage_d = {1'b1, stage_q[STAGES-1:1]};
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_OFF;
      stage_q <= '1;
      step_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      iso_q   <= 1'b1;
      on_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      // Status outputs are registered from the next state so the clamp never glitches.
      iso_q   <= (state_d != ST_ON);
      on_q    <= (state_d == ST_ON);
      busy_q  <= !(state_d inside {ST_OFF, ST_ON});
    end
  end

  assign stage_en_n  = stage_q;
  assign iso_en      = iso_q;
  assign pwr_on      = on_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule
